// File: rtl/apple_placer.sv
// apple_placer: holds the apple position, detects the snake head eating it on
// a game tick, and re-places it from sampled random coordinates. Candidates are
// rejected if out of bounds or on the head/previous apple cell. The body store
// is asked about each remaining candidate through an occ_req/occ_ack query.
// Optional feature macro: APPLE_TIMEOUT_EN relocates an uneaten apple after
// TIMEOUT_TICKS game ticks.
module apple_placer #(
  parameter int unsigned X_MIN         = 20,
  parameter int unsigned X_MAX         = 620,
  parameter int unsigned Y_MIN         = 20,
  parameter int unsigned Y_MAX         = 460,
  parameter int unsigned INIT_X        = 320,
  parameter int unsigned INIT_Y        = 240,
  parameter int unsigned MAX_RETRY     = 15,
  parameter int unsigned SCORE_W       = 8,
  parameter int unsigned TIMEOUT_TICKS = 200
) (
  input  logic               VGA_clk,
  input  logic               reset,
  input  logic               game_tick,
  input  logic [9:0]         head_X,
  input  logic [8:0]         head_Y,
  input  logic [9:0]         rand_X,
  input  logic [8:0]         rand_Y,
  output logic               occ_req,
  output logic [9:0]         occ_X,
  output logic [8:0]         occ_Y,
  input  logic               occ_ack,
  input  logic               occ_hit,
  output logic [9:0]         apple_X,
  output logic [8:0]         apple_Y,
  output logic               apple_valid,
  output logic               eat,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam logic [9:0]    XMIN   = 10'(X_MIN);
  localparam logic [9:0]    XMAX   = 10'(X_MAX);
  localparam logic [8:0]    YMIN   = 9'(Y_MIN);
  localparam logic [8:0]    YMAX   = 9'(Y_MAX);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {PLACED, SAMPLE, QUERY} state_e;

  state_e             state_q, state_d;
  logic [9:0]         apple_x_q, apple_x_d;
  logic [8:0]         apple_y_q, apple_y_d;
  logic               apple_valid_q, apple_valid_d;
  logic               eat_q, eat_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               occ_req_q, occ_req_d;
  logic [9:0]         occ_x_q, occ_x_d;
  logic [8:0]         occ_y_q, occ_y_d;
  logic [RW-1:0]      retry_q, retry_d;

  logic          cand_legal;
  logic [RW-1:0] retry_inc;

`ifdef APPLE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TIMEOUT_TICKS - 1);
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  // Timeout tick counter register
  always_ff @(posedge VGA_clk) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_TICKS != 0);
`endif

  // Candidate legality and saturating retry increment
  always_comb begin
    cand_legal = (rand_X >= XMIN) && (rand_X <= XMAX) &&
                 (rand_Y >= YMIN) && (rand_Y <= YMAX) &&
                 !((rand_X == head_X) && (rand_Y == head_Y)) &&
                 !((rand_X == apple_x_q) && (rand_Y == apple_y_q));
    retry_inc  = (retry_q >= RETRY_MAX) ? RETRY_MAX : retry_q + 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state_q       <= PLACED;
      apple_x_q     <= 10'(INIT_X);
      apple_y_q     <= 9'(INIT_Y);
      apple_valid_q <= 1'b1;
      eat_q         <= 1'b0;
      score_q       <= '0;
      occ_req_q     <= 1'b0;
      occ_x_q       <= '0;
      occ_y_q       <= '0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      apple_x_q     <= apple_x_d;
      apple_y_q     <= apple_y_d;
      apple_valid_q <= apple_valid_d;
      eat_q         <= eat_d;
      score_q       <= score_d;
      occ_req_q     <= occ_req_d;
      occ_x_q       <= occ_x_d;
      occ_y_q       <= occ_y_d;
      retry_q       <= retry_d;
    end
  end

  // Next-state logic: eat/timeout detection, sampling, query handshake, commit
  always_comb begin
    state_d       = state_q;
    apple_x_d     = apple_x_q;
    apple_y_d     = apple_y_q;
    apple_valid_d = apple_valid_q;
    eat_d         = 1'b0;
    score_d       = score_q;
    occ_req_d     = occ_req_q;
    occ_x_d       = occ_x_q;
    occ_y_d       = occ_y_q;
    retry_d       = retry_q;
`ifdef APPLE_TIMEOUT_EN
    tick_cnt_d    = tick_cnt_q;
`endif
    unique case (state_q)
      PLACED: begin
        if (game_tick && (head_X == apple_x_q) && (head_Y == apple_y_q)) begin
          eat_d         = 1'b1;
          score_d       = (score_q == '1) ? score_q : score_q + 1'b1;
          apple_valid_d = 1'b0;
          retry_d       = '0;
          state_d       = SAMPLE;
`ifdef APPLE_TIMEOUT_EN
          tick_cnt_d    = '0;
        end else if (game_tick) begin
          // Eat is checked first so it wins over a coincident timeout
          if (tick_cnt_q >= TICK_LAST) begin
            apple_valid_d = 1'b0;
            retry_d       = '0;
            state_d       = SAMPLE;
            tick_cnt_d    = '0;
          end else begin
            tick_cnt_d    = tick_cnt_q + 1'b1;
          end
`endif
        end
      end
      SAMPLE: begin
        if (!cand_legal) begin
          retry_d = retry_inc;
        end else if (retry_q < RETRY_MAX) begin
          occ_x_d   = rand_X;
          occ_y_d   = rand_Y;
          occ_req_d = 1'b1;
          state_d   = QUERY;
        end else begin
          apple_x_d     = rand_X;
          apple_y_d     = rand_Y;
          apple_valid_d = 1'b1;
          state_d       = PLACED;
`ifdef APPLE_TIMEOUT_EN
          tick_cnt_d    = '0;
`endif
        end
      end
      QUERY: begin
        if (occ_ack && occ_req_q) begin
          occ_req_d = 1'b0;
          if (occ_hit) begin
            retry_d = retry_inc;
            state_d = SAMPLE;
          end else begin
            // The held query coordinates are the candidate being committed
            apple_x_d     = occ_x_q;
            apple_y_d     = occ_y_q;
            apple_valid_d = 1'b1;
            state_d       = PLACED;
`ifdef APPLE_TIMEOUT_EN
            tick_cnt_d    = '0;
`endif
          end
        end
      end
      default: state_d = PLACED;
    endcase
  end

  assign occ_req     = occ_req_q;
  assign occ_X       = occ_x_q;
  assign occ_Y       = occ_y_q;
  assign apple_X     = apple_x_q;
  assign apple_Y     = apple_y_q;
  assign apple_valid = apple_valid_q;
  assign eat         = eat_q;
  assign score       = score_q;

endmodule

// File: tb/tb_apple_placer.sv
// Directed bench for apple_placer: reset, eat/place, rejection, query hold,
// forced placement, score saturation, reset during query and (with
// APPLE_TIMEOUT_EN) apple timeout.
module tb_apple_placer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       game_tick = 1'b0;
  logic [9:0] head_x = '0;
  logic [8:0] head_y = '0;
  logic [9:0] rand_x = '0;
  logic [8:0] rand_y = '0;
  logic       occ_ack = 1'b0;
  logic       occ_hit = 1'b0;
  logic       occ_req;
  logic [9:0] occ_x;
  logic [8:0] occ_y;
  logic [9:0] apple_x;
  logic [8:0] apple_y;
  logic       apple_valid;
  logic       eat;
  logic [7:0] score;

  int total = 0;
  int bad   = 0;

  apple_placer #(.TIMEOUT_TICKS(4)) dut (
    .VGA_clk    (clk),
    .reset      (reset),
    .game_tick  (game_tick),
    .head_X     (head_x),
    .head_Y     (head_y),
    .rand_X     (rand_x),
    .rand_Y     (rand_y),
    .occ_req    (occ_req),
    .occ_X      (occ_x),
    .occ_Y      (occ_y),
    .occ_ack    (occ_ack),
    .occ_hit    (occ_hit),
    .apple_X    (apple_x),
    .apple_Y    (apple_y),
    .apple_valid(apple_valid),
    .eat        (eat),
    .score      (score)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; game_tick = 1'b0; occ_ack = 1'b0; occ_hit = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic eat_apple(input int hx, input int hy);
    head_x = 10'(hx); head_y = 9'(hy);
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
  endtask

  task automatic place(input int rx, input int ry);
    rand_x = 10'(rx); rand_y = 9'(ry);
    step();
    occ_ack = 1'b1; occ_hit = 1'b0;
    step();
    occ_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (apple_x !== 10'd320) begin bad++; $display("FAIL rst_apple_x got=%0d exp=320", apple_x); end
    total++; if (apple_y !== 9'd240) begin bad++; $display("FAIL rst_apple_y got=%0d exp=240", apple_y); end
    total++; if (apple_valid !== 1'b1) begin bad++; $display("FAIL rst_valid got=%0b exp=1", apple_valid); end
    total++; if (score !== 8'd0) begin bad++; $display("FAIL rst_score got=%0d exp=0", score); end
    total++; if (eat !== 1'b0) begin bad++; $display("FAIL rst_eat got=%0b exp=0", eat); end
    total++; if (occ_req !== 1'b0) begin bad++; $display("FAIL rst_occ_req got=%0b exp=0", occ_req); end
    total++; if (occ_x !== 10'd0 || occ_y !== 9'd0) begin bad++; $display("FAIL rst_occ_xy got=%0d,%0d exp=0,0", occ_x, occ_y); end
  endtask

  task automatic test_eat_place();
    do_reset();
    head_x = 10'd320; head_y = 9'd240;
    step();
    total++; if (eat !== 1'b0) begin bad++; $display("FAIL no_tick_no_eat got=%0b exp=0", eat); end
    eat_apple(320, 240);
    total++; if (eat !== 1'b1) begin bad++; $display("FAIL eat_pulse got=%0b exp=1", eat); end
    total++; if (score !== 8'd1) begin bad++; $display("FAIL eat_score got=%0d exp=1", score); end
    total++; if (apple_valid !== 1'b0) begin bad++; $display("FAIL eat_valid got=%0b exp=0", apple_valid); end
    rand_x = 10'd100; rand_y = 9'd200;
    step();
    total++; if (eat !== 1'b0) begin bad++; $display("FAIL eat_one_cycle got=%0b exp=0", eat); end
    total++; if (occ_req !== 1'b1) begin bad++; $display("FAIL eat_occ_req got=%0b exp=1", occ_req); end
    total++; if (occ_x !== 10'd100 || occ_y !== 9'd200) begin bad++; $display("FAIL eat_occ_xy got=%0d,%0d exp=100,200", occ_x, occ_y); end
    occ_ack = 1'b1; occ_hit = 1'b0;
    step();
    occ_ack = 1'b0;
    total++; if (apple_x !== 10'd100 || apple_y !== 9'd200) begin bad++; $display("FAIL eat_commit got=%0d,%0d exp=100,200", apple_x, apple_y); end
    total++; if (apple_valid !== 1'b1) begin bad++; $display("FAIL eat_commit_valid got=%0b exp=1", apple_valid); end
    total++; if (occ_req !== 1'b0) begin bad++; $display("FAIL eat_req_drop got=%0b exp=0", occ_req); end
  endtask

  task automatic test_reject();
    int rx[6] = '{630, 320, 19, 100, 621, 100};
    int ry[6] = '{200, 240, 200, 19, 200, 461};
    do_reset();
    eat_apple(320, 240);
    // a stray ack while no query is outstanding must be ignored
    occ_ack = 1'b1; occ_hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_x = 10'(rx[i]); rand_y = 9'(ry[i]);
      step();
      total++; if (occ_req !== 1'b0 || apple_valid !== 1'b0) begin bad++; $display("FAIL reject_%0d req=%0b valid=%0b exp=0,0", i, occ_req, apple_valid); end
    end
    occ_ack = 1'b0;
    rand_x = 10'd100; rand_y = 9'd200;
    step();
    total++; if (occ_req !== 1'b1) begin bad++; $display("FAIL reject_then_req got=%0b exp=1", occ_req); end
    total++; if (occ_x !== 10'd100 || occ_y !== 9'd200) begin bad++; $display("FAIL reject_occ_xy got=%0d,%0d exp=100,200", occ_x, occ_y); end
    occ_ack = 1'b1;
    step();
    occ_ack = 1'b0;
    eat_apple(100, 200);
    place(620, 460);
    total++; if (apple_x !== 10'd620 || apple_y !== 9'd460 || apple_valid !== 1'b1) begin bad++; $display("FAIL bound_max got=%0d,%0d v=%0b exp=620,460 v=1", apple_x, apple_y, apple_valid); end
    eat_apple(620, 460);
    place(20, 20);
    total++; if (apple_x !== 10'd20 || apple_y !== 9'd20 || apple_valid !== 1'b1) begin bad++; $display("FAIL bound_min got=%0d,%0d v=%0b exp=20,20 v=1", apple_x, apple_y, apple_valid); end
  endtask

  task automatic test_query_hold();
    do_reset();
    eat_apple(320, 240);
    rand_x = 10'd100; rand_y = 9'd200;
    step();
    total++; if (occ_req !== 1'b1) begin bad++; $display("FAIL hold_req got=%0b exp=1", occ_req); end
    rand_x = 10'd50; rand_y = 9'd50;
    for (int i = 0; i < 5; i++) begin
      head_x = 10'd320; head_y = 9'd240; game_tick = 1'b1;
      step();
      game_tick = 1'b0;
      total++; if (occ_req !== 1'b1 || occ_x !== 10'd100 || occ_y !== 9'd200) begin bad++; $display("FAIL hold_%0d req=%0b xy=%0d,%0d exp=1 100,200", i, occ_req, occ_x, occ_y); end
      total++; if (eat !== 1'b0 || score !== 8'd1) begin bad++; $display("FAIL hold_tick_%0d eat=%0b score=%0d exp=0,1", i, eat, score); end
    end
    occ_ack = 1'b1; occ_hit = 1'b1;
    step();
    occ_ack = 1'b0; occ_hit = 1'b0;
    total++; if (occ_req !== 1'b0 || apple_valid !== 1'b0) begin bad++; $display("FAIL hit_drop req=%0b valid=%0b exp=0,0", occ_req, apple_valid); end
    rand_x = 10'd300; rand_y = 9'd300;
    step();
    total++; if (occ_req !== 1'b1 || occ_x !== 10'd300 || occ_y !== 9'd300) begin bad++; $display("FAIL requery req=%0b xy=%0d,%0d exp=1 300,300", occ_req, occ_x, occ_y); end
    occ_ack = 1'b1;
    step();
    occ_ack = 1'b0;
    total++; if (apple_x !== 10'd300 || apple_y !== 9'd300 || apple_valid !== 1'b1) begin bad++; $display("FAIL hit_commit got=%0d,%0d v=%0b exp=300,300 v=1", apple_x, apple_y, apple_valid); end
  endtask

  task automatic test_force();
    do_reset();
    eat_apple(320, 240);
    for (int i = 0; i < 15; i++) begin
      rand_x = 10'(100 + i); rand_y = 9'd200;
      step();
      total++; if (occ_req !== 1'b1) begin bad++; $display("FAIL force_query_%0d got=%0b exp=1", i, occ_req); end
      occ_ack = 1'b1; occ_hit = 1'b1;
      step();
      occ_ack = 1'b0; occ_hit = 1'b0;
    end
    rand_x = 10'd400; rand_y = 9'd400;
    step();
    total++; if (occ_req !== 1'b0) begin bad++; $display("FAIL force_no_req got=%0b exp=0", occ_req); end
    total++; if (apple_x !== 10'd400 || apple_y !== 9'd400 || apple_valid !== 1'b1) begin bad++; $display("FAIL force_commit got=%0d,%0d v=%0b exp=400,400 v=1", apple_x, apple_y, apple_valid); end
  endtask

  task automatic test_score_sat();
    int ax = 320;
    int ay = 240;
    do_reset();
    for (int n = 0; n < 254; n++) begin
      eat_apple(ax, ay);
      ax = (n % 2 == 0) ? 100 : 300;
      ay = (n % 2 == 0) ? 200 : 300;
      place(ax, ay);
    end
    total++; if (score !== 8'd254) begin bad++; $display("FAIL score_254 got=%0d exp=254", score); end
    eat_apple(ax, ay);
    total++; if (score !== 8'd255) begin bad++; $display("FAIL score_255 got=%0d exp=255", score); end
    place(500, 100);
    eat_apple(500, 100);
    total++; if (eat !== 1'b1 || score !== 8'd255) begin bad++; $display("FAIL score_sat eat=%0b score=%0d exp=1,255", eat, score); end
  endtask

  task automatic test_reset_in_query();
    do_reset();
    eat_apple(320, 240);
    place(100, 200);
    eat_apple(100, 200);
    rand_x = 10'd300; rand_y = 9'd300;
    step();
    total++; if (occ_req !== 1'b1) begin bad++; $display("FAIL rq_req got=%0b exp=1", occ_req); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (occ_req !== 1'b0) begin bad++; $display("FAIL rq_req_drop got=%0b exp=0", occ_req); end
    total++; if (apple_x !== 10'd320 || apple_y !== 9'd240 || apple_valid !== 1'b1) begin bad++; $display("FAIL rq_apple got=%0d,%0d v=%0b exp=320,240 v=1", apple_x, apple_y, apple_valid); end
    total++; if (score !== 8'd0) begin bad++; $display("FAIL rq_score got=%0d exp=0", score); end
  endtask

`ifdef APPLE_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 3; i++) eat_apple(0, 0);
    total++; if (apple_valid !== 1'b1) begin bad++; $display("FAIL to_early got=%0b exp=1", apple_valid); end
    eat_apple(0, 0);
    total++; if (apple_valid !== 1'b0 || eat !== 1'b0 || score !== 8'd0) begin bad++; $display("FAIL to_fire v=%0b eat=%0b score=%0d exp=0,0,0", apple_valid, eat, score); end
    place(100, 200);
    total++; if (apple_x !== 10'd100 || apple_y !== 9'd200 || apple_valid !== 1'b1) begin bad++; $display("FAIL to_place got=%0d,%0d v=%0b exp=100,200 v=1", apple_x, apple_y, apple_valid); end
    for (int i = 0; i < 3; i++) eat_apple(0, 0);
    eat_apple(100, 200);
    total++; if (eat !== 1'b1 || score !== 8'd1) begin bad++; $display("FAIL to_eat_wins eat=%0b score=%0d exp=1,1", eat, score); end
  endtask
`endif

  initial begin
    test_reset();
    test_eat_place();
    test_reject();
    test_query_hold();
    test_force();
    test_score_sat();
    test_reset_in_query();
`ifdef APPLE_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
